// File: rtl/hps_ext_xfer.sv
// HPS extension-bus transfer engine: command decode, shared write FIFO, per-channel reads.
// Optional push counter returned on status word 1 when HPS_EXT_XFER_WCNT_EN is defined.
module hps_ext_xfer #(
  parameter int          NUM_CH     = 4,
  parameter int          ADDR_W     = 5,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] CMD_WR     = 16'h61,
  parameter logic [15:0] CMD_RD     = 16'h62,
  parameter logic [15:0] CMD_STAT   = 16'h63
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 io_strobe,
  input  logic                 io_uio,
  input  logic [15:0]          io_din,
  output logic [15:0]          io_dout,
  output logic                 dout_en,
  input  logic [NUM_CH-1:0]    ch_req,
  input  logic [NUM_CH-1:0]    ch_ready,
  input  logic [16*NUM_CH-1:0] ch_din,
  output logic [15:0]          ch_dout,
  output logic [ADDR_W-1:0]    ch_addr,
  output logic [NUM_CH-1:0]    ch_wr,
  output logic [NUM_CH-1:0]    ch_rd
);

  localparam int         PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);

  typedef struct packed {
    logic [2:0]        ch;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } entry_t;

  logic [4:0]        wordCnt_q, wordCnt_d;
  logic [15:0]       cmd_q, cmd_d;
  logic              cs_q, cs_d;
  logic [2:0]        ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addrNext;
  logic              ovf_q, ovf_d;
  logic [PTR_W:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [15:0]       ioDout_q, ioDout_d;
  logic              doutEn_q, doutEn_d;
  logic [NUM_CH-1:0] chWr_q, chWr_d, chRd_q, chRd_d;
  logic [ADDR_W-1:0] chAddr_q, chAddr_d;
  logic [15:0]       chDout_q, chDout_d;

  entry_t            fifoMem [FIFO_DEPTH];
  entry_t            head, pushEntry;
  logic              fifoEmpty, fifoFull, pop, pushReq, push, statRd;
  logic [NUM_CH-1:0] chSel, headSel;
  logic [15:0]       rdData, statWord1;

  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                     (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign head      = fifoMem[rdPtr_q[PTR_W-1:0]];
  assign statRd    = io_uio && io_strobe && (wordCnt_q == 5'd1) && (cmd_q == CMD_STAT);
  assign addrNext  = (addr_q == '1) ? addr_q : addr_q + ADDR_W'(1);

  always_comb begin
    chSel   = '0;
    headSel = '0;
    rdData  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      chSel[i]   = (ch_q == 3'(i));
      headSel[i] = (head.ch == 3'(i));
      if (ch_q == 3'(i)) rdData = ch_din[16*i +: 16];
    end
  end

  // The head entry blocks the queue until its own channel is ready.
  assign pop = !fifoEmpty && |(headSel & ch_ready);

  always_comb begin
    wordCnt_d      = wordCnt_q;
    cmd_d          = cmd_q;
    cs_d           = cs_q;
    ch_d           = ch_q;
    addr_d         = addr_q;
    ovf_d          = ovf_q;
    rdPtr_d        = rdPtr_q;
    wrPtr_d        = wrPtr_q;
    ioDout_d       = ioDout_q;
    doutEn_d       = doutEn_q;
    chWr_d         = '0;
    chRd_d         = '0;
    chAddr_d       = chAddr_q;
    chDout_d       = chDout_q;
    pushReq        = 1'b0;
    pushEntry.ch   = ch_q;
    pushEntry.addr = addr_q;
    pushEntry.data = io_din;

    if (pop) begin
      rdPtr_d  = rdPtr_q + (PTR_W+1)'(1);
      chWr_d   = headSel;
      chAddr_d = head.addr;
      chDout_d = head.data;
    end

    if (!io_uio) begin
      wordCnt_d = '0;
      cs_d      = 1'b0;
      doutEn_d  = 1'b0;
      ioDout_d  = '0;
    end else if (io_strobe) begin
      ioDout_d = '0;
      if (wordCnt_q != 5'd31) wordCnt_d = wordCnt_q + 5'd1;
      if (wordCnt_q == 5'd0) begin
        cmd_d    = io_din;
        doutEn_d = (io_din == CMD_WR) || (io_din == CMD_RD) || (io_din == CMD_STAT);
        if (io_din == CMD_STAT) begin
          ioDout_d = {4'hE, ovf_q, !fifoEmpty, 2'b00, 8'(ch_req)};
          ovf_d    = 1'b0;
        end
      end else if (wordCnt_q == 5'd1) begin
        if (cmd_q == CMD_STAT) ioDout_d = statWord1;
        if (io_din[15:12] == 4'hF && {1'b0, io_din[11:9]} < NUM_CH_L) begin
          cs_d   = 1'b1;
          ch_d   = io_din[11:9];
          addr_d = io_din[ADDR_W-1:0];
        end else begin
          cs_d = 1'b0;
        end
      end else if (wordCnt_q >= 5'd3 && cs_q) begin
        if (cmd_q == CMD_WR) begin
          pushReq = 1'b1;
          if (fifoFull && !pop) ovf_d = 1'b1;
          addr_d = addrNext;
        end else if (cmd_q == CMD_RD && fifoEmpty) begin
          chRd_d   = chSel;
          chAddr_d = addr_q;
          ioDout_d = rdData;
          addr_d   = addrNext;
        end
      end
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push = pushReq && (!fifoFull || pop);
    if (push) wrPtr_d = wrPtr_q + (PTR_W+1)'(1);
  end

`ifdef HPS_EXT_XFER_WCNT_EN
  logic [15:0] pushCnt_q, pushCnt_d;

  always_comb begin
    pushCnt_d = pushCnt_q;
    if (statRd)                              pushCnt_d = {15'd0, push};
    else if (push && pushCnt_q != 16'hFFFF)  pushCnt_d = pushCnt_q + 16'd1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) pushCnt_q <= '0;
    else          pushCnt_q <= pushCnt_d;
  end

  assign statWord1 = pushCnt_q;
`else
  logic unusedStatRd;
  assign unusedStatRd = statRd;
  assign statWord1    = '0;
`endif

  always_ff @(posedge clk_sys) begin
    if (push) fifoMem[wrPtr_q[PTR_W-1:0]] <= pushEntry;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wordCnt_q <= '0;
      cmd_q     <= '0;
      cs_q      <= 1'b0;
      ch_q      <= '0;
      addr_q    <= '0;
      ovf_q     <= 1'b0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      ioDout_q  <= '0;
      doutEn_q  <= 1'b0;
      chWr_q    <= '0;
      chRd_q    <= '0;
      chAddr_q  <= '0;
      chDout_q  <= '0;
    end else begin
      wordCnt_q <= wordCnt_d;
      cmd_q     <= cmd_d;
      cs_q      <= cs_d;
      ch_q      <= ch_d;
      addr_q    <= addr_d;
      ovf_q     <= ovf_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      ioDout_q  <= ioDout_d;
      doutEn_q  <= doutEn_d;
      chWr_q    <= chWr_d;
      chRd_q    <= chRd_d;
      chAddr_q  <= chAddr_d;
      chDout_q  <= chDout_d;
    end
  end

  assign io_dout = ioDout_q;
  assign dout_en = doutEn_q;
  assign ch_wr   = chWr_q;
  assign ch_rd   = chRd_q;
  assign ch_addr = chAddr_q;
  assign ch_dout = chDout_q;

endmodule

// File: tb/tb_hps_ext_xfer.sv
// Bench for hps_ext_xfer: queue-based transaction model checked every cycle plus directed literal checks.
module tb_hps_ext_xfer;

  localparam int DEPTH = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_strobe = 1'b0;
  logic        io_uio = 1'b0;
  logic [15:0] io_din = '0;
  logic [15:0] io_dout;
  logic        dout_en;
  logic [3:0]  ch_req = '0;
  logic [3:0]  ch_ready = 4'hF;
  logic [63:0] ch_din = 64'h4444_3333_2222_1111;
  logic [15:0] ch_dout;
  logic [4:0]  ch_addr;
  logic [3:0]  ch_wr;
  logic [3:0]  ch_rd;

  int errors = 0;
  int checks = 0;

  hps_ext_xfer dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .io_strobe(io_strobe), .io_uio(io_uio),
    .io_din(io_din), .io_dout(io_dout), .dout_en(dout_en), .ch_req(ch_req),
    .ch_ready(ch_ready), .ch_din(ch_din), .ch_dout(ch_dout), .ch_addr(ch_addr),
    .ch_wr(ch_wr), .ch_rd(ch_rd)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: the write FIFO is a plain queue, counters are integers.
  typedef struct { int ch; int addr; logic [15:0] dat; } mEntry_t;
  mEntry_t     mFifo[$];
  mEntry_t     mHead;
  int          mWord = 0, mCh = 0, mAddr = 0, mCnt = 0, mBefore = 0;
  logic [15:0] mCmd = '0;
  bit          mCs = 0, mOvf = 0;
  logic [15:0] eIo = '0, eDat = '0;
  logic        eEn = 1'b0;
  logic [3:0]  eWr = '0, eRd = '0;
  logic [4:0]  eAddr = '0;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mFifo.delete();
      mWord = 0; mCh = 0; mAddr = 0; mCnt = 0; mCmd = '0; mCs = 0; mOvf = 0;
      eIo = '0; eDat = '0; eEn = 1'b0; eWr = '0; eRd = '0; eAddr = '0;
    end else begin
      mBefore = mFifo.size();
      eWr = '0;
      eRd = '0;
      if (mBefore > 0 && ch_ready[mFifo[0].ch]) begin
        mHead = mFifo.pop_front();
        eWr   = 4'(1 << mHead.ch);
        eAddr = 5'(mHead.addr);
        eDat  = mHead.dat;
      end
      if (!io_uio) begin
        mWord = 0; mCs = 0; eEn = 1'b0; eIo = '0;
      end else if (io_strobe) begin
        eIo = '0;
        if (mWord == 0) begin
          mCmd = io_din;
          eEn  = (io_din == 16'h61 || io_din == 16'h62 || io_din == 16'h63);
          if (io_din == 16'h63) begin
            eIo  = {4'hE, mOvf, mBefore > 0, 2'b00, 4'h0, ch_req};
            mOvf = 0;
          end
        end else if (mWord == 1) begin
`ifdef HPS_EXT_XFER_WCNT_EN
          if (mCmd == 16'h63) begin eIo = 16'(mCnt); mCnt = 0; end
`endif
          mCs = (io_din[15:12] == 4'hF) && (int'(io_din[11:9]) < 4);
          if (mCs) begin mCh = int'(io_din[11:9]); mAddr = int'(io_din[4:0]); end
        end else if (mWord >= 3 && mCs) begin
          if (mCmd == 16'h61) begin
            if (mFifo.size() < DEPTH) begin
              mFifo.push_back('{ch: mCh, addr: mAddr, dat: io_din});
              if (mCnt < 65535) mCnt++;
            end else mOvf = 1;
            if (mAddr < 31) mAddr++;
          end else if (mCmd == 16'h62 && mBefore == 0) begin
            eRd   = 4'(1 << mCh);
            eAddr = 5'(mAddr);
            eIo   = ch_din[mCh*16 +: 16];
            if (mAddr < 31) mAddr++;
          end
        end
        if (mWord < 31) mWord++;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk_sys) begin
    checkOutput("cmp_io_dout", 32'(io_dout), 32'(eIo));
    checkOutput("cmp_dout_en", 32'(dout_en), 32'(eEn));
    checkOutput("cmp_ch_wr",   32'(ch_wr),   32'(eWr));
    checkOutput("cmp_ch_rd",   32'(ch_rd),   32'(eRd));
    checkOutput("cmp_ch_addr", 32'(ch_addr), 32'(eAddr));
    checkOutput("cmp_ch_dout", 32'(ch_dout), 32'(eDat));
  end

  // Record every write pulse for the directed drain checks.
  logic [3:0]  logWr[$];
  logic [4:0]  logAddr[$];
  logic [15:0] logDat[$];
  always @(negedge clk_sys) begin
    if (ch_wr != 4'h0) begin
      logWr.push_back(ch_wr);
      logAddr.push_back(ch_addr);
      logDat.push_back(ch_dout);
    end
  end

  task automatic clearLog();
    logWr.delete(); logAddr.delete(); logDat.delete();
  endtask

  task automatic checkLog(input int idx, input logic [3:0] wr, input logic [4:0] addr, input logic [15:0] dat);
    if (idx < logWr.size()) begin
      checkOutput($sformatf("log%0d_wr", idx),   32'(logWr[idx]),   32'(wr));
      checkOutput($sformatf("log%0d_addr", idx), 32'(logAddr[idx]), 32'(addr));
      checkOutput($sformatf("log%0d_dat", idx),  32'(logDat[idx]),  32'(dat));
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL log%0d_missing: actual=absent required=write pulse", idx);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] w);
    @(negedge clk_sys);
    io_din = w;
    io_strobe = 1'b1;
    @(negedge clk_sys);
    io_strobe = 1'b0;
  endtask

  task automatic applyBurst(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      io_din = base + 16'(i);
      io_strobe = 1'b1;
    end
    @(negedge clk_sys);
    io_strobe = 1'b0;
  endtask

  task automatic startXfer();
    @(negedge clk_sys);
    io_uio = 1'b1;
  endtask

  task automatic endXfer();
    @(negedge clk_sys);
    io_uio = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    waitCycles(3);
    checkOutput("reset_io_dout", 32'(io_dout), 32'h0);
    checkOutput("reset_ch_wr",   32'(ch_wr),   32'h0);
    reset_n = 1'b1;
    waitCycles(2);

    // Status with requests pending.
    ch_req = 4'b0101;
    startXfer();
    applyStimulus(16'h0063);
    checkOutput("stat_word0", 32'(io_dout), 32'hE005);
    checkOutput("stat_en",    32'(dout_en), 32'h1);
    applyStimulus(16'h0000);
    checkOutput("stat_word1", 32'(io_dout), 32'h0);
    checkOutput("stat_en_hold", 32'(dout_en), 32'h1);
    endXfer();
    checkOutput("stat_en_drop", 32'(dout_en), 32'h0);
    ch_req = 4'b0000;

    // Two-word write to channel 1 starting at address 3.
    clearLog();
    startXfer();
    applyStimulus(16'h0061);
    applyStimulus(16'hF203);
    applyStimulus(16'h0000);
    applyStimulus(16'hAAAA);
    applyStimulus(16'hBBBB);
    endXfer();
    waitCycles(3);
    checkOutput("wr2_count", 32'(logWr.size()), 32'd2);
    checkLog(0, 4'b0010, 5'd3, 16'hAAAA);
    checkLog(1, 4'b0010, 5'd4, 16'hBBBB);

    // Overflow: channel 0 blocked, 20 back-to-back words from address 20.
    clearLog();
    ch_ready = 4'b1110;
    startXfer();
    applyStimulus(16'h0061);
    applyStimulus(16'hF014);
    applyStimulus(16'h0000);
    applyBurst(20, 16'h1000);
    endXfer();
    checkOutput("ovf_no_drain", 32'(logWr.size()), 32'd0);
    startXfer();
    applyStimulus(16'h0063);
    checkOutput("stat_ovf", 32'(io_dout), 32'hEC00);
    endXfer();
    startXfer();
    applyStimulus(16'h0063);
    checkOutput("stat_ovf_cleared", 32'(io_dout), 32'hE400);
    endXfer();
    ch_ready = 4'hF;
    waitCycles(20);
    checkOutput("ovf_drain_count", 32'(logWr.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      checkLog(i, 4'b0001, (20 + i > 31) ? 5'd31 : 5'(20 + i), 16'h1000 + 16'(i));
    startXfer();
    applyStimulus(16'h0063);
    checkOutput("stat_empty", 32'(io_dout), 32'hE000);
    endXfer();

    // Read from channel 3 at the top address; address saturates.
    startXfer();
    applyStimulus(16'h0062);
    applyStimulus(16'hF61F);
    applyStimulus(16'h0000);
    ch_din[48 +: 16] = 16'h1234;
    applyStimulus(16'h0000);
    checkOutput("rd_data",  32'(io_dout), 32'h1234);
    checkOutput("rd_pulse", 32'(ch_rd),   32'h8);
    checkOutput("rd_addr",  32'(ch_addr), 32'd31);
    ch_din[48 +: 16] = 16'h5678;
    applyStimulus(16'h0000);
    checkOutput("rd2_data", 32'(io_dout), 32'h5678);
    checkOutput("rd2_addr", 32'(ch_addr), 32'd31);
    endXfer();

    // io_uio drops with entries queued; they still drain afterwards.
    clearLog();
    ch_ready = 4'h0;
    startXfer();
    applyStimulus(16'h0061);
    applyStimulus(16'hF400);
    applyStimulus(16'h0000);
    applyBurst(3, 16'h00C0);
    endXfer();
    checkOutput("hold_no_drain", 32'(logWr.size()), 32'd0);
    ch_ready = 4'hF;
    waitCycles(5);
    checkOutput("hold_drain_count", 32'(logWr.size()), 32'd3);
    for (int i = 0; i < 3; i++) checkLog(i, 4'b0100, 5'(i), 16'h00C0 + 16'(i));

    // Asynchronous reset with entries queued empties the FIFO.
    clearLog();
    ch_ready = 4'h0;
    startXfer();
    applyStimulus(16'h0061);
    applyStimulus(16'hF400);
    applyStimulus(16'h0000);
    applyBurst(3, 16'h00D0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_ch_addr", 32'(ch_addr), 32'h0);
    checkOutput("arst_ch_dout", 32'(ch_dout), 32'h0);
    checkOutput("arst_dout_en", 32'(dout_en), 32'h0);
    io_uio = 1'b0;
    waitCycles(2);
    reset_n = 1'b1;
    ch_ready = 4'hF;
    waitCycles(5);
    checkOutput("arst_no_drain", 32'(logWr.size()), 32'd0);
    startXfer();
    applyStimulus(16'h0063);
    checkOutput("arst_stat", 32'(io_dout), 32'hE000);
    endXfer();

`ifdef HPS_EXT_XFER_WCNT_EN
    startXfer();
    applyStimulus(16'h0061);
    applyStimulus(16'hF200);
    applyStimulus(16'h0000);
    applyBurst(5, 16'h0500);
    endXfer();
    waitCycles(4);
    startXfer();
    applyStimulus(16'h0063);
    applyStimulus(16'h0000);
    checkOutput("wcnt_five", 32'(io_dout), 32'd5);
    endXfer();
    startXfer();
    applyStimulus(16'h0063);
    applyStimulus(16'h0000);
    checkOutput("wcnt_cleared", 32'(io_dout), 32'd0);
    endXfer();
`endif

    waitCycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hps_ext_xfer.md
Name: hps_ext_xfer

Overview:
Parametrised HPS extension-bus transfer engine and the successor to the fixed IDE/CDDA data port. It decodes status, write and read commands on the 16-bit HPS UIO word stream and serves NUM_CH generic block channels, each with its own request line. Writes pass through a shared write FIFO drained per channel under ch_ready backpressure. Reads are prefetch-style.

Parameters:
NUM_CH, 4, number of channels, 1..8
ADDR_W, 5, channel register address width, 1..9
FIFO_DEPTH, 16, write FIFO depth in entries; power of 2, at least 2
CMD_WR, 'h61, write command code
CMD_RD, 'h62, read command code
CMD_STAT, 'h63, status command code

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
io_strobe  in  1  one-cycle word strobe from HPS
io_uio  in  1  UIO transaction active; low ends the transaction
io_din  in  16  word from HPS
io_dout  out  16  registered word to HPS
dout_en  out  1  block drives io_dout for the current command
ch_req  in  NUM_CH  per-channel service request
ch_ready  in  NUM_CH  channel accepts a write this cycle
ch_din  in  16*NUM_CH  per-channel read data; channel n occupies [16n+15:16n]
ch_dout  out  16  write data
ch_addr  out  ADDR_W  register address for the current write or read
ch_wr  out  NUM_CH  one-hot write pulse
ch_rd  out  NUM_CH  one-hot read pulse

Behaviour:
- Reset (reset_n low, asynchronous): io_dout=0, dout_en=0, ch_wr=0, ch_rd=0, ch_addr=0, ch_dout=0. Word counter, FIFO pointers, overflow flag and cs flags are cleared.
- Word counter: 5 bits, saturates at 31. Cleared while io_uio is low.
- io_uio low: dout_en=0, io_dout=0, cs cleared. FIFO contents are not flushed and continue to drain.
- Word 0: latch cmd. dout_en<=1 the following cycle if cmd is CMD_WR, CMD_RD or CMD_STAT.
- CMD_STAT at word 0: io_dout<={4'hE, ovf, fifo_nonempty, 2'b00, ch_req zero-extended to 8}. The same update clears ovf.
- Word 1 (header):
  - Header is valid when io_din[15:12]==4'hF and io_din[11:9]<NUM_CH.
  - Valid header: cs<=1, ch<=io_din[11:9], addr<=io_din[ADDR_W-1:0].
  - Invalid header: cs<=0. Later words produce no channel activity.
- Word 2 is reserved and ignored. Data starts at word 3.
- CMD_WR, word ≥3, cs=1:
  - Push {ch, addr, io_din}, then addr<=addr+1, saturating at all-ones.
  - FIFO full: the word is dropped, ovf<=1, and addr still advances.
- FIFO drain:
  - When the head entry's ch_ready bit is 1: pop the entry, drive ch_dout/ch_addr, and pulse ch_wr[ch] for one cycle, registered.
  - Throughput is at most one pop per cycle.
  - A push and a pop in the same cycle are both allowed, including when the FIFO is full (the pop frees the slot and the push is accepted).
  - The head blocks the queue when its channel is not ready; there is no reordering.
- CMD_RD, word ≥3, cs=1:
  - FIFO empty: ch_rd[ch]<=1, ch_addr<=addr, io_dout<=ch_din[ch] as sampled this cycle, then addr advances (saturating). io_dout is valid the cycle after the strobe.
  - FIFO non-empty: io_dout<=0 and no ch_rd pulse. HPS is required to poll status bit 10 first.
- ch_addr is shared between the drain path and the read path. A read cannot coincide with a drain because reads require an empty FIFO.
- io_dout returns to 0 on every strobe not otherwise covered above.
- Back-to-back strobes on consecutive cycles are supported.

Optional Feature:
Macro HPS_EXT_XFER_WCNT_EN.
- Defined:
  - A 16-bit saturating counter of accepted FIFO pushes.
  - CMD_STAT word 1 returns the counter value. The counter clears on that read, and a push in the same cycle counts as 1 after the clear.
  - Reset clears the counter.
- Undefined: the counter is absent, and CMD_STAT word 1 returns 0.

Test Plan:
- ch_req=4'b0101, send 'h63 -> io_dout=16'hE005 one cycle after the strobe, dout_en=1 until io_uio falls.
- CMD_WR, header 16'hF203 (ch1, addr 3), filler, data AAAA/BBBB with ch_ready=all ones -> ch_wr=4'b0010 twice, ch_addr 3 then 4, ch_dout AAAA then BBBB.
- ch_ready[0]=0, write 20 words to ch0 at FIFO_DEPTH=16 -> 16 stored, ovf=1, next status reads 16'hEC00 and a second status reads 16'hE400. Raise ch_ready -> 16 pulses, addresses contiguous, saturating at 31.
- CMD_RD, header 16'hF61F (ch3, addr 31), ch_din[3]=1234 -> ch_rd=4'b1000, io_dout=1234, ch_addr stays at 31 on the next read.
- Drop io_uio mid-write with 3 entries queued, then assert reset_n=0 -> before reset the entries drain normally; reset asynchronously empties the FIFO and zeroes all outputs.
- With HPS_EXT_XFER_WCNT_EN, write 5 accepted words, send status -> word 1 reads 5, a repeated status reads 0.
